// File: rtl/ex_fwd_hazard_unit.sv
// ex_fwd_hazard_unit
//   Shadows the ID/EX, EX/MEM and MEM/WB pipeline registers with a small
//   record pipeline. From these records it produces the EX-stage operand
//   forwarding selects. It also detects load-use hazards against the
//   instruction currently in ID.
//
//   Optional feature macro: LOAD_USE_STALL_EN
//     defined   - load-use detection drives stall_ID / bubble_EX
//     undefined - stall_ID / bubble_EX tied low (software fills the delay
//                 slot); a MEM-stage load still forwards with select 10
//
//   Ports
//     clk, rst          pipeline clock, synchronous active-high reset
//     hold              global freeze, no record advances
//     flush_ID          instruction in ID is killed
//     rs_ID, rt_ID      ID source registers, qualified by useRs_ID / useRt_ID
//     rw_ID             ID destination, qualified by RegWr_ID
//     MemtoReg_ID       ID instruction is a load
//     BusAFw, BusBFw    operand selects: 00 regfile, 01 WB data, 10 ALUout_M
//     stall_ID          hold PC and IF/ID this cycle
//     bubble_EX         ID/EX loads a NOP on the next edge
module ex_fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  flush_ID,
    input  logic [REG_ADDR_W-1:0] rs_ID,
    input  logic [REG_ADDR_W-1:0] rt_ID,
    input  logic                  useRs_ID,
    input  logic                  useRt_ID,
    input  logic [REG_ADDR_W-1:0] rw_ID,
    input  logic                  RegWr_ID,
    input  logic                  MemtoReg_ID,
    output logic [1:0]            BusAFw,
    output logic [1:0]            BusBFw,
    output logic                  stall_ID,
    output logic                  bubble_EX
);

    logic [REG_ADDR_W-1:0] r_ex_rs;
    logic [REG_ADDR_W-1:0] r_ex_rt;
    logic [REG_ADDR_W-1:0] r_ex_rw;
    logic                  r_ex_regwr;
    logic                  r_ex_load;
    logic [REG_ADDR_W-1:0] r_mem_rw;
    logic                  r_mem_regwr;
    logic                  r_mem_load;
    logic [REG_ADDR_W-1:0] r_wb_rw;
    logic                  r_wb_regwr;

    logic                  w_hazard;
    logic                  w_mem_fwd_ok;
    logic                  w_wb_fwd_ok;
    logic                  w_ex_kill;

    // The instruction leaving ID is replaced by a bubble when it is killed
    // or when it must wait one cycle behind a load.
    assign w_ex_kill = bubble_EX | flush_ID;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_rw     <= '0;
            r_ex_regwr  <= 1'b0;
            r_ex_load   <= 1'b0;
            r_mem_rw    <= '0;
            r_mem_regwr <= 1'b0;
            r_mem_load  <= 1'b0;
            r_wb_rw     <= '0;
            r_wb_regwr  <= 1'b0;
        end else if (!hold) begin
            r_wb_rw     <= r_mem_rw;
            r_wb_regwr  <= r_mem_regwr;
            r_mem_rw    <= r_ex_rw;
            r_mem_regwr <= r_ex_regwr;
            r_mem_load  <= r_ex_load;
            if (w_ex_kill) begin
                r_ex_rs    <= '0;
                r_ex_rt    <= '0;
                r_ex_rw    <= '0;
                r_ex_regwr <= 1'b0;
                r_ex_load  <= 1'b0;
            end else begin
                r_ex_rs    <= rs_ID;
                r_ex_rt    <= rt_ID;
                r_ex_rw    <= rw_ID;
                r_ex_regwr <= RegWr_ID;
                r_ex_load  <= MemtoReg_ID;
            end
        end
    end

`ifdef LOAD_USE_STALL_EN
    // With the stall in place a load can never sit in MEM with a dependent
    // in EX; masking it keeps the ALUout_M select from ever carrying a
    // load address.
    assign w_mem_fwd_ok = r_mem_regwr & ~r_mem_load & (r_mem_rw != '0);

    assign w_hazard = r_ex_load & r_ex_regwr & (r_ex_rw != '0) &
                      ((useRs_ID & (rs_ID == r_ex_rw)) |
                       (useRt_ID & (rt_ID == r_ex_rw)));

    assign stall_ID  = w_hazard & ~flush_ID;
    assign bubble_EX = w_hazard & ~flush_ID;
`else
    logic w_unused_cfg;

    assign w_mem_fwd_ok = r_mem_regwr & (r_mem_rw != '0);
    assign w_hazard     = 1'b0;
    assign stall_ID     = 1'b0;
    assign bubble_EX    = 1'b0;
    assign w_unused_cfg = ^{useRs_ID, useRt_ID, r_mem_load, w_hazard};
`endif

    assign w_wb_fwd_ok = r_wb_regwr & (r_wb_rw != '0);

    // Selects depend on records only; MEM is the newer producer and wins.
    always_comb begin
        BusAFw = 2'b00;
        BusBFw = 2'b00;
        if (w_mem_fwd_ok && (r_mem_rw == r_ex_rs)) begin
            BusAFw = 2'b10;
        end else if (w_wb_fwd_ok && (r_wb_rw == r_ex_rs)) begin
            BusAFw = 2'b01;
        end
        if (w_mem_fwd_ok && (r_mem_rw == r_ex_rt)) begin
            BusBFw = 2'b10;
        end else if (w_wb_fwd_ok && (r_wb_rw == r_ex_rt)) begin
            BusBFw = 2'b01;
        end
    end

endmodule

// File: tb/tb_ex_fwd_hazard_unit.sv
module tb_ex_fwd_hazard_unit;

`ifdef LOAD_USE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rw;
        logic       use_rs;
        logic       use_rt;
        logic       wr;
        logic       load;
    } instr_t;

    logic       clk;
    logic       rst;
    logic       hold;
    logic       flush_ID;
    logic [4:0] rs_ID;
    logic [4:0] rt_ID;
    logic       useRs_ID;
    logic       useRt_ID;
    logic [4:0] rw_ID;
    logic       RegWr_ID;
    logic       MemtoReg_ID;
    logic [1:0] BusAFw;
    logic [1:0] BusBFw;
    logic       stall_ID;
    logic       bubble_EX;

    int n_checks = 0;
    int n_fail   = 0;

    ex_fwd_hazard_unit #(.REG_ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .flush_ID   (flush_ID),
        .rs_ID      (rs_ID),
        .rt_ID      (rt_ID),
        .useRs_ID   (useRs_ID),
        .useRt_ID   (useRt_ID),
        .rw_ID      (rw_ID),
        .RegWr_ID   (RegWr_ID),
        .MemtoReg_ID(MemtoReg_ID),
        .BusAFw     (BusAFw),
        .BusBFw     (BusBFw),
        .stall_ID   (stall_ID),
        .bubble_EX  (bubble_EX)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: in-flight instructions by age (0 = EX, 1 = MEM, 2 = WB)
    instr_t m_pipe [3];
    instr_t cur;
    logic   cur_f, cur_h, cur_r;
    bit     m_known = 0;
    logic   m_last_stall = 1'b0;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic instr_t mk(input int rs, input int rt, input int rw,
                                  input bit urs, input bit urt, input bit wr, input bit ld);
        instr_t i;
        i.rs = 5'(rs); i.rt = 5'(rt); i.rw = 5'(rw);
        i.use_rs = urs; i.use_rt = urt; i.wr = wr; i.load = ld;
        return i;
    endfunction

    // Which older in-flight instruction last wrote src? The youngest one wins.
    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        int producer = 0;
        if (src == 0) return 2'b00;
        for (int age = 2; age >= 1; age--) begin
            if (m_pipe[age].wr && m_pipe[age].rw == src &&
                !(STALL_EN && age == 1 && m_pipe[age].load))
                producer = age;
        end
        case (producer)
            1:       return 2'b10;
            2:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic m_load_use();
        instr_t p = m_pipe[0];
        if (!STALL_EN || !p.load || !p.wr || p.rw == 0) return 1'b0;
        return (cur.use_rs && cur.rs == p.rw) || (cur.use_rt && cur.rt == p.rw);
    endfunction

    task automatic drive(input instr_t i, input logic f, input logic h, input logic r);
        cur = i; cur_f = f; cur_h = h; cur_r = r;
        rs_ID = i.rs; rt_ID = i.rt; rw_ID = i.rw;
        useRs_ID = i.use_rs; useRt_ID = i.use_rt;
        RegWr_ID = i.wr; MemtoReg_ID = i.load;
        flush_ID = f; hold = h; rst = r;
    endtask

    // Apply inputs, move to mid-cycle, compare against the model.
    task automatic cyc(input instr_t i, input logic f, input logic h, input logic r);
        logic exp_stall;
        drive(i, f, h, r);
        #4;
        if (m_known) begin
            exp_stall = m_load_use() && !cur_f;
            chk("fwdA", BusAFw, m_fwd(m_pipe[0].rs));
            chk("fwdB", BusBFw, m_fwd(m_pipe[0].rt));
            chk("stall", stall_ID, exp_stall);
            chk("bubble", bubble_EX, exp_stall);
        end
    endtask

    task automatic adv();
        logic kill;
        kill = (m_load_use() && !cur_f) || cur_f;
        m_last_stall = m_load_use() && !cur_f;
        @(posedge clk);
        #1;
        if (cur_r) begin
            for (int k = 0; k < 3; k++) m_pipe[k] = '0;
            m_known = 1;
        end else if (!cur_h) begin
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = kill ? instr_t'('0) : cur;
        end
    endtask

    task automatic step(input instr_t i);
        cyc(i, 1'b0, 1'b0, 1'b0);
        adv();
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) step('0);
    endtask

    function automatic instr_t rnd_instr();
        instr_t i;
        i.use_rs = 1'($urandom_range(0, 1));
        i.use_rt = 1'($urandom_range(0, 1));
        i.rs     = i.use_rs ? 5'($urandom_range(0, 7)) : 5'd0;
        i.rt     = i.use_rt ? 5'($urandom_range(0, 7)) : 5'd0;
        i.wr     = ($urandom_range(0, 3) != 0);
        i.rw     = 5'($urandom_range(0, 7));
        i.load   = i.wr && ($urandom_range(0, 2) == 0);
        return i;
    endfunction

    instr_t add_r3, sub_dep, or_dep, lw_r4, add_dep, nop_i;

    initial begin
        nop_i   = '0;
        add_r3  = mk(1, 2, 3, 1, 1, 1, 0);
        sub_dep = mk(3, 3, 5, 1, 1, 1, 0);
        or_dep  = mk(1, 3, 6, 1, 1, 1, 0);
        lw_r4   = mk(1, 0, 4, 1, 0, 1, 1);
        add_dep = mk(4, 2, 7, 1, 1, 1, 0);

        // Reset held two cycles with random ID inputs
        cyc(rnd_instr(), 1'b0, 1'b0, 1'b1);
        adv();
        cyc(rnd_instr(), 1'b0, 1'b0, 1'b1);
        chk("rst_A", BusAFw, 2'b00);
        chk("rst_B", BusBFw, 2'b00);
        chk("rst_stall", stall_ID, 1'b0);
        adv();
        cyc(nop_i, 1'b0, 1'b0, 1'b0);
        chk("rst_rel_stall", stall_ID, 1'b0);
        chk("rst_rel_A", BusAFw, 2'b00);
        adv();

        // MEM forward on both operands
        step(add_r3);
        step(sub_dep);
        cyc(nop_i, 1'b0, 1'b0, 1'b0);
        chk("mem_fwd_A", BusAFw, 2'b10);
        chk("mem_fwd_B", BusBFw, 2'b10);
        adv();
        drain();

        // WB forward
        step(add_r3);
        step(nop_i);
        step(or_dep);
        cyc(nop_i, 1'b0, 1'b0, 1'b0);
        chk("wb_fwd_B", BusBFw, 2'b01);
        chk("wb_fwd_A", BusAFw, 2'b00);
        adv();
        drain();

        // Back-to-back producers: MEM wins
        step(add_r3);
        step(add_r3);
        step(or_dep);
        cyc(nop_i, 1'b0, 1'b0, 1'b0);
        chk("prio_B", BusBFw, 2'b10);
        adv();
        drain();

        // Load-use
        step(lw_r4);
        cyc(add_dep, 1'b0, 1'b0, 1'b0);
        chk("lu_stall", stall_ID, STALL_EN);
        chk("lu_bubble", bubble_EX, STALL_EN);
        adv();
        if (STALL_EN) begin
            cyc(add_dep, 1'b0, 1'b0, 1'b0);
            chk("lu_stall_once", stall_ID, 1'b0);
            adv();
        end
        cyc(nop_i, 1'b0, 1'b0, 1'b0);
        chk("lu_fwd_A", BusAFw, STALL_EN ? 2'b01 : 2'b10);
        adv();
        drain();

        // Register 0
        step(mk(1, 2, 0, 1, 1, 1, 0));
        step(mk(0, 0, 8, 1, 1, 1, 0));
        cyc(nop_i, 1'b0, 1'b0, 1'b0);
        chk("r0_A", BusAFw, 2'b00);
        chk("r0_B", BusBFw, 2'b00);
        adv();
        step(mk(1, 0, 0, 1, 0, 1, 1));
        cyc(mk(0, 0, 9, 1, 1, 1, 0), 1'b0, 1'b0, 1'b0);
        chk("r0_nostall", stall_ID, 1'b0);
        adv();
        drain();

        // Flush beats hazard
        step(lw_r4);
        cyc(add_dep, 1'b1, 1'b0, 1'b0);
        chk("flush_stall", stall_ID, 1'b0);
        chk("flush_bubble", bubble_EX, 1'b0);
        adv();
        cyc(add_dep, 1'b0, 1'b0, 1'b0);
        chk("flush_ex_bubble", BusAFw, 2'b00);
        chk("flush_nostall", stall_ID, 1'b0);
        adv();
        drain();

        // Hold freezes selects
        step(add_r3);
        step(mk(1, 2, 5, 1, 1, 1, 0));
        step(mk(3, 5, 6, 1, 1, 1, 0));
        for (int k = 0; k < 3; k++) begin
            cyc(nop_i, 1'b0, 1'b1, 1'b0);
            chk("hold_A", BusAFw, 2'b01);
            chk("hold_B", BusBFw, 2'b10);
            adv();
        end
        cyc(nop_i, 1'b0, 1'b0, 1'b0);
        chk("resume_A", BusAFw, 2'b01);
        chk("resume_B", BusBFw, 2'b10);
        adv();
        drain();

        // Hold with hazard
        step(lw_r4);
        for (int k = 0; k < 2; k++) begin
            cyc(add_dep, 1'b0, 1'b1, 1'b0);
            chk("hold_hz_stall", stall_ID, STALL_EN);
            adv();
        end
        cyc(add_dep, 1'b0, 1'b0, 1'b0);
        chk("hold_hz_rel", stall_ID, STALL_EN);
        adv();
        drain();

        // Reset mid-operation
        step(add_r3);
        step(sub_dep);
        cyc(nop_i, 1'b0, 1'b0, 1'b1);
        adv();
        cyc(nop_i, 1'b0, 1'b0, 1'b0);
        chk("midrst_A", BusAFw, 2'b00);
        chk("midrst_B", BusBFw, 2'b00);
        adv();

        // Random traffic; ID holds its instruction while stalled or frozen
        cur = rnd_instr();
        for (int n = 0; n < 3000; n++) begin
            instr_t nxt;
            logic f, h, r;
            nxt = (m_last_stall || cur_h) ? cur : rnd_instr();
            f = ($urandom_range(0, 7) == 0);
            h = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 99) == 0);
            cyc(nxt, f, h, r);
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
